// File: rtl/wb_arbiter_if.sv
// Writeback packet type and the FU -> ROB writeback bus that wb_arbiter sits on.
// The master modport drives the FU side and the ROB ready; the slave modport is the arbiter.
typedef struct packed {
  logic [5:0]  rob_idx;
  logic [1:0]  epoch;
  logic        is_branch;
  logic        mispredict;
  logic [15:0] data;
} fu_wb_t;

interface wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int REQ_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   fu_valid;
  logic [NUM_REQ-1:0]   fu_ready;
  fu_wb_t [NUM_REQ-1:0] fu_pkt;
  logic                 flush_valid;
  logic                 wb_valid;
  logic                 wb_ready;
  fu_wb_t               wb_pkt;
  logic [REQ_W-1:0]     wb_grant_id;
  logic                 busy;

  modport master (
    output fu_valid, fu_pkt, flush_valid, wb_ready,
    input  fu_ready, wb_valid, wb_pkt, wb_grant_id, busy
  );

  modport slave (
    input  fu_valid, fu_pkt, flush_valid, wb_ready,
    output fu_ready, wb_valid, wb_pkt, wb_grant_id, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Shares the ROB writeback port among NUM_REQ FUs: 1-entry slot per FU, lockable round-robin grant.
// Optional macro WB_ARB_BRANCH_PRIO_EN: branch packets win arbitration, with a starvation guard.
module wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] r_occ;
  fu_wb_t             r_pkt [NUM_REQ];
  logic [REQ_W-1:0]   r_rr_ptr;
  logic [REQ_W-1:0]   r_locked_id;
  logic [REQ_W-1:0]   r_last_grant;
  logic               r_lock;

  logic [REQ_W-1:0]   w_grant;
  logic [REQ_W-1:0]   w_rr_next;
  logic               w_wb_valid;
  logic               w_hs;
  logic [NUM_REQ-1:0] w_drain;
  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_capture;

  // First set bit of mask scanning upward from ptr, modulo NUM_REQ.
  function automatic logic [REQ_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [REQ_W-1:0]   ptr);
    logic [REQ_W-1:0] pick;
    int               idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (mask[REQ_W'(idx)]) pick = REQ_W'(idx);
    end
    return pick;
  endfunction

`ifdef WB_ARB_BRANCH_PRIO_EN
  logic [2:0]         r_br_cnt;
  logic [NUM_REQ-1:0] w_br_mask;
  logic [NUM_REQ-1:0] w_nb_mask;
  logic               w_starve;

  always_comb begin
    w_br_mask = '0;
    w_nb_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_br_mask[i] = r_occ[i] &  r_pkt[i].is_branch;
      w_nb_mask[i] = r_occ[i] & ~r_pkt[i].is_branch;
    end
  end

  assign w_starve = (r_br_cnt >= 3'd4) && (|w_nb_mask);
`endif

  always_comb begin
    w_grant = rr_pick(r_occ, r_rr_ptr);
`ifdef WB_ARB_BRANCH_PRIO_EN
    if (w_starve)
      w_grant = rr_pick(w_nb_mask, r_rr_ptr);
    else if (|w_br_mask)
      w_grant = rr_pick(w_br_mask, r_rr_ptr);
`endif
    if (r_lock) w_grant = r_locked_id;
  end

  assign w_wb_valid = |r_occ;
  assign w_hs       = w_wb_valid && bus.wb_ready;
  assign w_rr_next  = (w_grant == REQ_W'(NUM_REQ - 1)) ? '0 : w_grant + REQ_W'(1);

  always_comb begin
    w_drain = '0;
    w_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_drain[i] = w_hs && (w_grant == REQ_W'(i));
      w_ready[i] = !bus.flush_valid && (!r_occ[i] || w_drain[i]);
    end
  end

  assign w_capture = bus.fu_valid & w_ready;

  // Slot stage: control state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ        <= '0;
      r_rr_ptr     <= '0;
      r_lock       <= 1'b0;
      r_locked_id  <= '0;
      r_last_grant <= '0;
`ifdef WB_ARB_BRANCH_PRIO_EN
      r_br_cnt     <= '0;
`endif
    end else begin
      if (w_wb_valid) r_last_grant <= w_grant;
      if (bus.flush_valid) begin
        r_occ    <= '0;
        r_rr_ptr <= '0;
        r_lock   <= 1'b0;
`ifdef WB_ARB_BRANCH_PRIO_EN
        r_br_cnt <= '0;
`endif
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          // A capture in the draining cycle keeps the slot full with the new packet.
          if (w_capture[i])    r_occ[i] <= 1'b1;
          else if (w_drain[i]) r_occ[i] <= 1'b0;
        end
        if (w_hs) begin
          r_lock   <= 1'b0;
          r_rr_ptr <= w_rr_next;
`ifdef WB_ARB_BRANCH_PRIO_EN
          if (!r_pkt[w_grant].is_branch) r_br_cnt <= '0;
          else if (r_br_cnt != 3'd7)     r_br_cnt <= r_br_cnt + 3'd1;
`endif
        end else if (w_wb_valid) begin
          r_lock      <= 1'b1;
          r_locked_id <= w_grant;
        end
      end
    end
  end

  // Slot stage: packet data, no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_capture[i]) r_pkt[i] <= bus.fu_pkt[i];
    end
  end

  assign bus.fu_ready    = w_ready;
  assign bus.wb_valid    = w_wb_valid;
  assign bus.wb_pkt      = w_wb_valid ? r_pkt[w_grant] : '0;
  assign bus.wb_grant_id = w_wb_valid ? w_grant : r_last_grant;
  assign bus.busy        = |r_occ;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus pushes expected {grant, rob_idx} retirements into a
// scoreboard queue; a negedge monitor pops and compares on every writeback handshake.
module tb_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int REQ_W   = $clog2(NUM_REQ);

  typedef struct {
    logic [REQ_W-1:0] gid;
    logic [5:0]       rob;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  wb_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  wb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic fu_wb_t mk(input int rob, input logic br);
    fu_wb_t p;
    p.rob_idx    = 6'(rob);
    p.epoch      = 2'b01;
    p.is_branch  = br;
    p.mispredict = br;
    p.data       = 16'(rob * 3 + 1);
    return p;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int gid, input int rob);
    exp_t e;
    e.gid = REQ_W'(gid);
    e.rob = 6'(rob);
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.wb_valid && bus.wb_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got grant=%0d rob=%0d, required no retirement",
                 bus.wb_grant_id, bus.wb_pkt.rob_idx);
      end else begin
        e = q.pop_front();
        if (bus.wb_grant_id !== e.gid || bus.wb_pkt.rob_idx !== e.rob) begin
          n_err++;
          $display("FAIL sb_retire: got grant=%0d rob=%0d, required grant=%0d rob=%0d",
                   bus.wb_grant_id, bus.wb_pkt.rob_idx, e.gid, e.rob);
        end
      end
    end
  end

  // Protocol properties
  logic             st_prev = 1'b0;
  fu_wb_t           st_pkt;
  logic [REQ_W-1:0] st_gid;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (st_prev && bus.wb_valid && (bus.wb_pkt !== st_pkt || bus.wb_grant_id !== st_gid)) begin
        n_err++;
        $display("FAIL stall_stable: got grant=%0d rob=%0d, required grant=%0d rob=%0d",
                 bus.wb_grant_id, bus.wb_pkt.rob_idx, st_gid, st_pkt.rob_idx);
      end
      if (bus.wb_valid && bus.wb_ready && !dut.r_occ[dut.w_grant]) begin
        n_err++;
        $display("FAIL hs_empty_slot: got occ=%b grant=%0d, required occupied grant", dut.r_occ, dut.w_grant);
      end
      if (!$onehot0(dut.w_drain)) begin
        n_err++;
        $display("FAIL drain_onehot0: got drain=%b, required at most one bit", dut.w_drain);
      end
    end
    st_prev = (rst_n === 1'b1) && bus.wb_valid && !bus.wb_ready && !bus.flush_valid;
    st_pkt  = bus.wb_pkt;
    st_gid  = bus.wb_grant_id;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.fu_valid    = '0;
    bus.fu_pkt      = '0;
    bus.flush_valid = 1'b0;
    bus.wb_ready    = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;

    // Reset / idle
    @(negedge clk);
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_fu_ready", 32'(bus.fu_ready), 32'h7);
    chk("rst_wb_pkt", 32'(bus.wb_pkt), 0);
    chk("rst_grant_id", 32'(bus.wb_grant_id), 0);

    // All three FUs valid together, round-robin 0,1,2
    cyc();
    bus.fu_valid  = 3'b111;
    bus.fu_pkt[0] = mk(5, 1'b0);
    bus.fu_pkt[1] = mk(9, 1'b0);
    bus.fu_pkt[2] = mk(12, 1'b0);
    bus.wb_ready  = 1'b1;
    push(0, 5); push(1, 9); push(2, 12);
    cyc();
    bus.fu_valid = '0;
    @(negedge clk);
    chk("rr_busy_c1", 32'(bus.busy), 1);
    repeat (3) cyc();
    @(negedge clk);
    chk("rr_busy_c4", 32'(bus.busy), 0);
    chk("rr_idle_valid", 32'(bus.wb_valid), 0);
    chk("idle_grant_hold", 32'(bus.wb_grant_id), 2);
    chk("idle_pkt_zero", 32'(bus.wb_pkt), 0);

    // FU1 held under back-pressure while FU0 fills
    cyc();
    bus.wb_ready  = 1'b0;
    bus.fu_valid  = 3'b010;
    bus.fu_pkt[1] = mk(7, 1'b0);
    push(1, 7); push(0, 3);
    cyc();
    bus.fu_valid  = 3'b001;
    bus.fu_pkt[0] = mk(3, 1'b0);
    @(negedge clk);
    chk("stall_rob_1", 32'(bus.wb_pkt.rob_idx), 7);
    chk("stall_gid_1", 32'(bus.wb_grant_id), 1);
    cyc();
    bus.fu_valid = '0;
    @(negedge clk);
    chk("stall_rob_2", 32'(bus.wb_pkt.rob_idx), 7);
    chk("stall_gid_2", 32'(bus.wb_grant_id), 1);
    chk("stall_fu_ready", 32'(bus.fu_ready), 32'h4);
    cyc();
    @(negedge clk);
    chk("stall_rob_3", 32'(bus.wb_pkt.rob_idx), 7);
    chk("stall_gid_3", 32'(bus.wb_grant_id), 1);
    cyc();
    bus.wb_ready = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    chk("stall_drained", 32'(bus.busy), 0);

    // Back-to-back on FU2: drain and capture in the same cycle
    cyc();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        bus.fu_valid  = 3'b100;
        bus.fu_pkt[2] = mk(20 + k, 1'b0);
        push(2, 20 + k);
      end else begin
        bus.fu_valid = '0;
      end
      @(negedge clk);
      if (k < 4) chk("b2b_fu_ready", 32'(bus.fu_ready[2]), 1);
      if (k > 0) chk("b2b_wb_valid", 32'(bus.wb_valid), 1);
      cyc();
    end

    // Move rr_ptr to 2, stall slots 0/2 (locks grant 2), then flush
    bus.fu_valid  = 3'b010;
    bus.fu_pkt[1] = mk(40, 1'b0);
    push(1, 40);
    cyc();
    bus.fu_valid = '0;
    cyc();
    bus.wb_ready  = 1'b0;
    bus.fu_valid  = 3'b101;
    bus.fu_pkt[0] = mk(30, 1'b0);
    bus.fu_pkt[2] = mk(31, 1'b0);
    cyc();
    bus.fu_valid = '0;
    @(negedge clk);
    chk("pre_flush_gid", 32'(bus.wb_grant_id), 2);
    chk("pre_flush_rob", 32'(bus.wb_pkt.rob_idx), 31);
    cyc();
    bus.flush_valid = 1'b1;
    @(negedge clk);
    chk("flush_fu_ready", 32'(bus.fu_ready), 0);
    cyc();
    bus.flush_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", 32'(bus.wb_valid), 0);
    chk("post_flush_busy", 32'(bus.busy), 0);
    chk("post_flush_ready", 32'(bus.fu_ready), 32'h7);
    cyc();
    bus.fu_valid  = 3'b110;
    bus.fu_pkt[1] = mk(50, 1'b0);
    bus.fu_pkt[2] = mk(51, 1'b0);
    bus.wb_ready  = 1'b1;
    push(1, 50); push(2, 51);
    cyc();
    bus.fu_valid = '0;
    repeat (2) cyc();

    // Reset while stalled: held packet is lost
    bus.wb_ready  = 1'b0;
    bus.fu_valid  = 3'b001;
    bus.fu_pkt[0] = mk(60, 1'b0);
    cyc();
    bus.fu_valid = '0;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stall_valid", 32'(bus.wb_valid), 0);
    chk("rst_stall_busy", 32'(bus.busy), 0);
    chk("rst_stall_gid", 32'(bus.wb_grant_id), 0);
    chk("rst_stall_ready", 32'(bus.fu_ready), 32'h7);
    bus.wb_ready = 1'b1;
    repeat (2) cyc();

`ifdef WB_ARB_BRANCH_PRIO_EN
    // Branch on slot 1 beats ALU on slot 0 at rr_ptr=0
    bus.fu_valid  = 3'b011;
    bus.fu_pkt[0] = mk(1, 1'b0);
    bus.fu_pkt[1] = mk(2, 1'b1);
    push(1, 2); push(0, 1);
    cyc();
    bus.fu_valid = '0;
    repeat (3) cyc();
    // Five branches on slot 1 with slot 0 waiting: slot 0 wins after the 4th
    push(1, 11); push(1, 12); push(1, 13); push(1, 14); push(0, 10); push(1, 15);
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        bus.fu_valid  = (k == 0) ? 3'b011 : 3'b010;
        if (k == 0) bus.fu_pkt[0] = mk(10, 1'b0);
        bus.fu_pkt[1] = mk(11 + k, 1'b1);
      end else begin
        bus.fu_valid = '0;
      end
      cyc();
    end
    repeat (3) cyc();
`endif

    repeat (3) cyc();
    chk("sb_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the ROB's single writeback port (wb_valid/wb_ready/wb_pkt) among NUM_REQ functional units (ALU, BRU, LSU, ...).
- Each requester gets a 1-entry holding slot.
- A round-robin arbiter picks one occupied slot per cycle; the grant is locked while the ROB back-pressures.
- A pipeline flush empties all slots.
- Sits between the FU writeback outputs and the ROB/CDB broadcast.

Parameters:
- NUM_REQ, 3, number of FU writeback requesters (>=2).
- REQ_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- fu_valid  input  NUM_REQ  per-FU writeback valid
- fu_ready  output  NUM_REQ  per-FU accept
- fu_pkt  input  NUM_REQ x fu_wb_t  per-FU writeback packet (rob_idx, epoch, is_branch, mispredict, ...)
- flush_valid  input  1  pipeline nuke; drops all held packets
- wb_valid  output  1  packet presented to ROB/CDB
- wb_ready  input  1  ROB accepts (low during recovery/flush)
- wb_pkt  output  fu_wb_t  selected packet
- wb_grant_id  output  REQ_W  index of the slot driving wb_pkt
- busy  output  1  any slot occupied

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - all slots empty; rr_ptr=0; lock=0.
  - Outputs after reset: wb_valid=0, wb_pkt='0, wb_grant_id=0, busy=0, fu_ready='1.
- Slot i state: occ[i] flag plus pkt[i] register.
- Input handshake:
  - fu_ready[i] = !flush_valid && (!occ[i] || drain[i]).
  - drain[i] = (grant==i && wb_valid && wb_ready).
  - Capture on fu_valid[i] && fu_ready[i]; occ[i] is set next cycle.
  - Same-cycle drain + capture: the slot stays occupied and holds the new packet (no bubble).
- Latency: a packet accepted in cycle N can appear on wb_valid in cycle N+1 at the earliest. There is no combinational path from fu_pkt to wb_pkt.
- Arbitration (combinational over occ):
  - If lock=1: grant = locked_id.
  - Else: grant = first occupied slot scanning from rr_ptr upward, modulo NUM_REQ.
- Outputs:
  - wb_valid = |occ.
  - wb_pkt = pkt[grant]; wb_pkt='0 when wb_valid=0.
  - wb_grant_id = grant; it holds its last value when idle.
- Lock and stall:
  - lock is set when wb_valid && !wb_ready; locked_id = grant.
  - lock is cleared on the handshake.
  - While stalled, wb_pkt and wb_grant_id must be stable, even if a higher-priority slot fills.
- Round-robin: on handshake, rr_ptr <= grant+1, wrapping from NUM_REQ-1 to 0. Otherwise rr_ptr is unchanged.
- Fairness: with all slots continuously occupied and wb_ready=1, each requester is granted exactly once every NUM_REQ cycles.
- Flush (flush_valid=1):
  - Synchronous: all occ cleared, lock cleared, rr_ptr reset to 0.
  - No captures that cycle (fu_ready=0).
  - wb_valid may still be high combinationally that cycle. The ROB ignores it because wb_ready=0 during flush.
- Epoch: not filtered here; the ROB discards stale epochs. Packets are passed through unmodified.
- Empty: wb_valid=0, rr_ptr frozen.
- Single requester occupied: it is granted regardless of rr_ptr.
- Reset mid-stall: all state cleared; held packets are lost.
- Assertions (bench):
  - no handshake with occ[grant]=0.
  - wb_pkt stable while wb_valid && !wb_ready.
  - onehot0 of the drain vector.

Optional Feature:
- Macro: WB_ARB_BRANCH_PRIO_EN.
- Defined: when lock=0, any occupied slot with pkt.is_branch=1 beats round-robin. Among several branch slots, round-robin order from rr_ptr applies. A branch grant still updates rr_ptr.
  - Purpose: minimise mispredict-to-recovery latency.
  - A starvation guard forces a non-branch grant after 4 consecutive branch grants while a non-branch slot is occupied. It uses a 3-bit counter, reset to 0 by reset, flush or any non-branch grant.
- Undefined: pure round-robin; no counter is synthesised.

Test Plan:
- Reset then idle -> wb_valid=0, busy=0, fu_ready=3'b111, wb_pkt='0.
- FU0, FU1 and FU2 all valid in cycle 0 with rob_idx 5, 9 and 12; wb_ready=1 -> wb_pkt.rob_idx = 5, 9, 12 in cycles 1, 2, 3; wb_grant_id = 0, 1, 2; busy falls in cycle 4.
- FU1 held (rob_idx 7); wb_ready=0 for 3 cycles while FU0 fills -> wb_pkt.rob_idx=7 and wb_grant_id=1 stable all 3 cycles. On wb_ready=1 rob_idx 7 drains, then FU0's packet next cycle.
- Continuous back-to-back on FU2 with wb_ready=1 -> fu_ready[2] stays 1 and one packet retires per cycle (drain+capture, no bubble).
- Slots 0 and 2 occupied, flush_valid pulse -> next cycle wb_valid=0, busy=0, rr_ptr=0; fu_ready=0 during the flush cycle.
- With WB_ARB_BRANCH_PRIO_EN: slot0 ALU and slot1 branch (mispredict=1) both occupied, rr_ptr=0 -> slot1 granted first. With 5 back-to-back branches on slot1 and slot0 occupied -> slot0 granted no later than after the 4th branch.
